// File: rtl/bus_encoder_pkg.sv
// Shared constants and types for the bus-select priority encoder.
package bus_encoder_pkg;

  localparam int unsigned N_SRC  = 24;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CODE_W-1:0] NONE_CODE = 5'd31;

  localparam int unsigned R0_SRC    = 0;
  localparam int unsigned R15_SRC   = 15;
  localparam int unsigned HI_SRC    = 16;
  localparam int unsigned LO_SRC    = 17;
  localparam int unsigned ZHIGH_SRC = 18;
  localparam int unsigned ZLOW_SRC  = 19;
  localparam int unsigned PC_SRC    = 20;
  localparam int unsigned MDR_SRC   = 21;
  localparam int unsigned INPORT_SRC = 22;
  localparam int unsigned C_SRC     = 23;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } enc_state_e;

endpackage

// File: rtl/bus_encoder_if.sv
// Source-enable input handshake, select-code output handshake and error status.
interface bus_encoder_if
  import bus_encoder_pkg::*;
#(
  parameter int unsigned N_SRC  = bus_encoder_pkg::N_SRC,
  parameter int unsigned CODE_W = bus_encoder_pkg::CODE_W,
  parameter int unsigned CNT_W  = bus_encoder_pkg::CNT_W
);
  logic [N_SRC-1:0]  src_out;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] sel_code;
  logic              sel_valid;
  logic              sel_ready;
  logic              sel_none;
  logic              sel_conflict;
  logic              err_sticky;
  logic              err_clr;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output src_out, in_valid, sel_ready, err_clr,
    input  in_ready, sel_code, sel_valid, sel_none, sel_conflict,
           err_sticky, conflict_cnt
  );

  modport slave (
    input  src_out, in_valid, sel_ready, err_clr,
    output in_ready, sel_code, sel_valid, sel_none, sel_conflict,
           err_sticky, conflict_cnt
  );
endinterface

// File: rtl/bus_encoder_prio_enc.sv
// Combinational lowest-index-wins encoder with none/conflict detection.
module bus_prio_enc
  import bus_encoder_pkg::*;
#(
  parameter int unsigned N_SRC  = bus_encoder_pkg::N_SRC,
  parameter int unsigned CODE_W = bus_encoder_pkg::CODE_W
) (
  input  logic [N_SRC-1:0]  src_i,
  output logic [CODE_W-1:0] code_o,
  output logic              none_o,
  output logic              conflict_o
);
  logic seen;

  // Scanning upward and latching only the first hit gives lowest-index priority.
  always_comb begin
    code_o     = '1;
    conflict_o = 1'b0;
    seen       = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_i[i]) begin
        if (seen) begin
          conflict_o = 1'b1;
        end else begin
          code_o = CODE_W'(i);
          seen   = 1'b1;
        end
      end
    end
    none_o = ~seen;
  end
endmodule

// File: rtl/bus_encoder.sv
// One-entry registered stage holding the bus-select code, plus conflict tracking.
module bus_encoder
  import bus_encoder_pkg::*;
#(
  parameter int unsigned N_SRC  = bus_encoder_pkg::N_SRC,
  parameter int unsigned CODE_W = bus_encoder_pkg::CODE_W,
  parameter int unsigned CNT_W  = bus_encoder_pkg::CNT_W
) (
  input logic         clock,
  input logic         clear,
  bus_encoder_if.slave bus
);
  enc_state_e        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              none_q, none_d;
  logic              conf_q, conf_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CODE_W-1:0] enc_code;
  logic              enc_none;
  logic              enc_conf;
  logic              accept;

  bus_prio_enc #(
    .N_SRC  (N_SRC),
    .CODE_W (CODE_W)
  ) u_prio (
    .src_i      (bus.src_out),
    .code_o     (enc_code),
    .none_o     (enc_none),
    .conflict_o (enc_conf)
  );

  assign bus.in_ready     = (state_q == EMPTY) || bus.sel_ready;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.sel_valid    = (state_q == FULL);
  assign bus.sel_code     = code_q;
  assign bus.sel_none     = none_q;
  assign bus.sel_conflict = conf_q;
  assign bus.err_sticky   = err_q;
  assign bus.conflict_cnt = cnt_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= EMPTY;
      code_q  <= '1;
      none_q  <= 1'b0;
      conf_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      none_q  <= none_d;
      conf_q  <= conf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    none_d  = none_q;
    conf_d  = conf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (accept) begin
      state_d = FULL;
      code_d  = enc_code;
      none_d  = enc_none;
      conf_d  = enc_conf;
    end else if (state_q == FULL && bus.sel_ready) begin
      // Draining restores the idle values so EMPTY always reads as "drive zero".
      state_d = EMPTY;
      code_d  = '1;
      none_d  = 1'b0;
      conf_d  = 1'b0;
    end

    if (bus.err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (accept && enc_conf) begin
      err_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_bus_encoder.sv
// Directed bench for bus_encoder with a per-cycle behavioural reference.
module tb_bus_encoder;
  localparam int unsigned NS = 24;
  localparam int unsigned CW = 5;
  localparam int unsigned KW = 8;

  logic clock;
  logic clear;
  int   total;
  int   bad;

  bus_encoder_if #(.N_SRC(NS), .CODE_W(CW), .CNT_W(KW)) bus ();

  bus_encoder #(.N_SRC(NS), .CODE_W(CW), .CNT_W(KW)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state, derived straight from the behavioural rules.
  int m_valid, m_code, m_none, m_conf, m_err, m_cnt;

  function automatic int lowest_set(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++)
      if (v[i]) return i;
    return 31;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge clear) begin
    int acc, pc;
    if (clear) begin
      m_valid = 0; m_code = 31; m_none = 0; m_conf = 0; m_err = 0; m_cnt = 0;
    end else begin
      pc  = $countones(bus.src_out);
      acc = (bus.in_valid && (m_valid == 0 || bus.sel_ready)) ? 1 : 0;
      if (acc != 0) begin
        m_valid = 1;
        m_code  = lowest_set(bus.src_out);
        m_none  = (pc == 0) ? 1 : 0;
        m_conf  = (pc >= 2) ? 1 : 0;
      end else if (m_valid != 0 && bus.sel_ready) begin
        m_valid = 0; m_code = 31; m_none = 0; m_conf = 0;
      end
      if (bus.err_clr) begin
        m_err = 0; m_cnt = 0;
      end else if (acc != 0 && pc >= 2) begin
        m_err = 1;
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
    end
  end

  always @(negedge clock) begin
    check("m_valid",  int'(bus.sel_valid),    m_valid);
    check("m_code",   int'(bus.sel_code),     m_code);
    check("m_none",   int'(bus.sel_none),     m_none);
    check("m_conf",   int'(bus.sel_conflict), m_conf);
    check("m_err",    int'(bus.err_sticky),   m_err);
    check("m_cnt",    int'(bus.conflict_cnt), m_cnt);
    check("m_ready",  int'(bus.in_ready),     (m_valid == 0 || bus.sel_ready) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [NS-1:0] s, input logic v, input logic r, input logic c);
    bus.src_out   = s;
    bus.in_valid  = v;
    bus.sel_ready = r;
    bus.err_clr   = c;
  endtask

  logic [NS-1:0] vec_src [6];
  int            vec_code[6];
  int            vec_conf[6];
  int            vec_none[6];

  initial begin
    total = 0;
    bad   = 0;
    clear = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_valid", int'(bus.sel_valid), 0);
    check("rst_code",  int'(bus.sel_code), 31);
    check("rst_none",  int'(bus.sel_none), 0);
    check("rst_conf",  int'(bus.sel_conflict), 0);
    check("rst_err",   int'(bus.err_sticky), 0);
    check("rst_cnt",   int'(bus.conflict_cnt), 0);
    clear = 1'b0;
    #1;
    check("rst_ready", int'(bus.in_ready), 1);

    @(negedge clock);
    drive(24'h1 << 20, 1'b1, 1'b1, 1'b0);
    tick();
    check("pc_code",  int'(bus.sel_code), 20);
    check("pc_valid", int'(bus.sel_valid), 1);
    check("pc_none",  int'(bus.sel_none), 0);
    check("pc_conf",  int'(bus.sel_conflict), 0);

    drive((24'h1 << 3) | (24'h1 << 21), 1'b1, 1'b1, 1'b0);
    tick();
    check("cf_code", int'(bus.sel_code), 3);
    check("cf_conf", int'(bus.sel_conflict), 1);
    check("cf_err",  int'(bus.err_sticky), 1);
    check("cf_cnt",  int'(bus.conflict_cnt), 1);

    drive('0, 1'b1, 1'b1, 1'b0);
    tick();
    check("zero_code", int'(bus.sel_code), 31);
    check("zero_none", int'(bus.sel_none), 1);
    check("zero_cnt",  int'(bus.conflict_cnt), 1);

    vec_src[0] = 24'h800000; vec_code[0] = 23; vec_conf[0] = 0; vec_none[0] = 0;
    vec_src[1] = 24'hC00000; vec_code[1] = 22; vec_conf[1] = 1; vec_none[1] = 0;
    vec_src[2] = 24'h000001; vec_code[2] = 0;  vec_conf[2] = 0; vec_none[2] = 0;
    vec_src[3] = 24'hFFFFFF; vec_code[3] = 0;  vec_conf[3] = 1; vec_none[3] = 0;
    vec_src[4] = 24'h010000; vec_code[4] = 16; vec_conf[4] = 0; vec_none[4] = 0;
    vec_src[5] = 24'h0A0000; vec_code[5] = 17; vec_conf[5] = 1; vec_none[5] = 0;
    for (int i = 0; i < 6; i++) begin
      drive(vec_src[i], 1'b1, 1'b1, 1'b0);
      tick();
      check("vec_code", int'(bus.sel_code), vec_code[i]);
      check("vec_conf", int'(bus.sel_conflict), vec_conf[i]);
      check("vec_none", int'(bus.sel_none), vec_none[i]);
    end
    check("vec_cnt", int'(bus.conflict_cnt), 4);

    drive(24'h1 << 5, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(24'h3 << (2 * i), 1'b1, 1'b0, 1'b0);
      #1;
      check("hold_ready", int'(bus.in_ready), 0);
      tick();
      check("hold_code",  int'(bus.sel_code), 5);
      check("hold_valid", int'(bus.sel_valid), 1);
      check("hold_conf",  int'(bus.sel_conflict), 0);
    end
    check("hold_cnt", int'(bus.conflict_cnt), 4);
    drive(24'h1 << 7, 1'b1, 1'b1, 1'b0);
    tick();
    check("nobubble_code",  int'(bus.sel_code), 7);
    check("nobubble_valid", int'(bus.sel_valid), 1);

    drive(24'h1 << 9, 1'b0, 1'b1, 1'b0);
    tick();
    check("drain_valid", int'(bus.sel_valid), 0);
    check("drain_code",  int'(bus.sel_code), 31);

    drive(24'h1 << 9, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_valid", int'(bus.sel_valid), 0);

    for (int i = 0; i < 300; i++) begin
      drive(24'h3, 1'b1, 1'b1, 1'b0);
      tick();
    end
    check("sat_cnt", int'(bus.conflict_cnt), 255);
    tick();
    check("sat_hold", int'(bus.conflict_cnt), 255);
    drive(24'h3, 1'b1, 1'b1, 1'b1);
    tick();
    check("clr_cnt", int'(bus.conflict_cnt), 0);
    check("clr_err", int'(bus.err_sticky), 0);

    drive(24'h1 << 12, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_clear_valid", int'(bus.sel_valid), 1);
    drive(24'h1 << 12, 1'b0, 1'b0, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    check("aclr_valid", int'(bus.sel_valid), 0);
    check("aclr_code",  int'(bus.sel_code), 31);
    check("aclr_none",  int'(bus.sel_none), 0);
    check("aclr_conf",  int'(bus.sel_conflict), 0);
    check("aclr_err",   int'(bus.err_sticky), 0);
    check("aclr_cnt",   int'(bus.conflict_cnt), 0);
    #1;
    clear = 1'b0;
    #1;
    check("aclr_ready", int'(bus.in_ready), 1);
    drive(24'h1 << 22, 1'b1, 1'b0, 1'b0);
    tick();
    check("post_code", int'(bus.sel_code), 22);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_encoder.md
BUS_ENCODER -- requirements
Module: bus_encoder

Interface
REQ-001 Parameter N_SRC, default 24, number of bus source-enable lines.
REQ-002 Parameter CODE_W, default 5, width of encoded bus-select code.
REQ-003 Parameter CNT_W, default 8, width of conflict counter.
REQ-004 Port clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port clear  input  1  reset, asynchronous, active-high.
REQ-006 Port src_out  input  N_SRC  source-enable lines. Bits 0-15 are R0out-R15out; 16 HIout, 17 LOout, 18 ZHighout, 19 ZLowout, 20 PCout, 21 MDRout, 22 InPortout, 23 Cout.
REQ-007 Port in_valid  input  1  src_out is presented this cycle.
REQ-008 Port in_ready  output  1  encoder accepts src_out this cycle.
REQ-009 Port sel_code  output  CODE_W  registered bus-mux select code.
REQ-010 Port sel_valid  output  1  sel_code holds a valid entry.
REQ-011 Port sel_ready  input  1  bus mux consumes the entry.
REQ-012 Port sel_none  output  1  entry had zero enables set.
REQ-013 Port sel_conflict  output  1  entry had two or more enables set.
REQ-014 Port err_sticky  output  1  a conflict has occurred since the last err_clr or reset.
REQ-015 Port err_clr  input  1  synchronous clear of err_sticky and conflict_cnt.
REQ-016 Port conflict_cnt  output  CNT_W  saturating count of accepted conflicting entries.

Function
REQ-017 Two states: EMPTY (sel_valid=0) and FULL (sel_valid=1).
REQ-018 in_ready shall be 1 in EMPTY, or in FULL when sel_ready=1, so full throughput is one entry per cycle.
REQ-019 Accept = in_valid && in_ready; on accept, the entry is registered and the state is FULL the next cycle (latency 1 clock).
REQ-020 In FULL with sel_ready=1 and no accept, the state goes to EMPTY; with an accept, it stays FULL and loads the new entry.
REQ-021 In FULL with sel_ready=0, sel_code, sel_none and sel_conflict shall hold stable.
REQ-022 sel_code = index of the lowest-numbered set bit of src_out; priority is lowest index wins.
REQ-023 If no bit is set, sel_code = all ones (31) and sel_none=1; the bus mux treats 31 as "drive zero".
REQ-024 sel_conflict=1 iff popcount(src_out) >= 2; sel_code still follows REQ-022.
REQ-025 In EMPTY, sel_code shall read 31, and sel_none and sel_conflict shall read 0.
REQ-026 On an accepted conflict, err_sticky is set and conflict_cnt increments by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-027 err_clr has priority over a same-cycle conflict: the counter becomes 0 and err_sticky becomes 0.
REQ-028 in_valid=0 shall never change state or flags.
REQ-029 src_out bits at index >= N_SRC do not exist; CODE_W shall satisfy 2^CODE_W > N_SRC.

Reset
REQ-030 clear=1 shall immediately force EMPTY and set sel_valid=0, sel_code=31, sel_none=0, sel_conflict=0, err_sticky=0, conflict_cnt=0.
REQ-031 A clear asserted while FULL discards the held entry, with no handshake completion.
REQ-032 in_ready shall be 1 on the first edge after clear deasserts.

Structure
REQ-033 A shared package shall hold the source-index constants (R0_SRC..C_SRC = 0..23), NONE_CODE = 31, N_SRC and CODE_W.
REQ-034 One combinational sub-module, bus_prio_enc, shall compute code, none and conflict from src_out; bus_encoder holds the registers and FSM.

Verification
REQ-035 Reset, then src_out=bit 20 (PCout), in_valid=1, sel_ready=1 -> next cycle sel_code=20, sel_valid=1, sel_none=0, sel_conflict=0.
REQ-036 src_out = bits 3 and 21 set -> sel_code=3, sel_conflict=1, err_sticky=1, conflict_cnt=1.
REQ-037 src_out=0 accepted -> sel_code=31, sel_none=1, no counter change.
REQ-038 FULL with sel_ready=0 for 5 cycles and changing src_out -> in_ready=0, outputs unchanged; then sel_ready=1 with in_valid=1 -> new entry loaded next cycle with no bubble.
REQ-039 300 consecutive conflicting accepts -> conflict_cnt=255 and holding; err_clr coincident with a conflict -> counter 0, err_sticky 0.
REQ-040 clear pulsed mid-FULL between edges -> sel_valid drops without waiting for a clock edge, and all outputs match REQ-030.
